pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter WDOG_MAX, default 16'hFFFF: consecutive-stall count that declares a hang.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-low (rst==0 resets on the next posedge).
REQ-004 stallreq_if_i / stallreq_id_i / stallreq_ex_i / stallreq_mem_i  in  1 each  stage stall requests.
REQ-005 branch_flag_i  in  1  taken-branch/mispredict resolved in EX; branch_target_i  in  32  its target.
REQ-006 excp_i  in  1  exception at commit; excp_num_i  in  4  cause; eentry_i  in  32  exception entry.
REQ-007 ertn_i  in  1  exception return at commit; era_i  in  32  return address.
REQ-008 fetch_ready_i  in  1  fetch unit accepts redirect this cycle.
REQ-009 stall_o  out  5  hold per register: [0] pc, [1] if_id, [2] id_ex, [3] ex_mem, [4] mem_wb.
REQ-010 flush_o  out  5  clear per register, same bit mapping as stall_o.
REQ-011 redirect_valid_o  out  1; redirect_pc_o  out  32  fetch redirect request and target.
REQ-012 excp_num_o  out  4  last accepted exception cause; hang_o  out  1  sticky watchdog flag.

Function
REQ-013 FSM states RUN and WAIT only; WAIT = redirect pending, not yet accepted by fetch.
REQ-014 Event priority, highest first: excp_i, ertn_i, branch_flag_i, stall requests.
REQ-015 RUN, no event: stall level s = highest requesting stage (if=1, id=2, ex=3, mem=4, none=0); stall_o[i]=1 for all i<s, else 0.
REQ-016 RUN, no event, s>0 and s<5: flush_o[s]=1 (bubble into first non-stalled register); all other flush_o bits 0.
REQ-017 RUN, excp_i: flush_o=5'b11111, stall_o=0, redirect_valid_o=1, redirect_pc_o=eentry_i (combinational, same cycle); excp_num_o <= excp_num_i.
REQ-018 RUN, ertn_i without excp_i: as REQ-017 but redirect_pc_o=era_i; excp_num_o unchanged.
REQ-019 RUN, branch_flag_i only: flush_o=5'b00110, stall_o=0, redirect_valid_o=1, redirect_pc_o=branch_target_i; stall requests ignored this cycle.
REQ-020 Redirect in RUN with fetch_ready_i=1: remain RUN; with fetch_ready_i=0: latch target, enter WAIT.
REQ-021 WAIT: redirect_valid_o=1, redirect_pc_o=latched target, stall_o=5'b00001, flush_o=5'b00010; stall requests ignored.
REQ-022 WAIT, fetch_ready_i=1 and no excp_i/ertn_i: return to RUN next cycle.
REQ-023 WAIT, excp_i or ertn_i: apply REQ-017/018 outputs that cycle and overwrite latched target; stay WAIT unless fetch_ready_i=1.
REQ-024 WAIT, branch_flag_i: ignored.
REQ-025 Watchdog: 16-bit counter increments each cycle stall_o[0]=1, clears when stall_o[0]=0; saturates at WDOG_MAX.
REQ-026 Counter reaching WDOG_MAX sets hang_o=1; hang_o stays 1 until reset; no effect on pipeline control.

Reset
REQ-027 On rst==0 at posedge: state RUN, latched target 32'h0, excp_num_o 4'h0, watchdog 0, hang_o 0.
REQ-028 While in reset cycle and after it with no inputs: stall_o=0, flush_o=0, redirect_valid_o=0, redirect_pc_o=32'h0.
REQ-029 Reset in WAIT discards pending redirect; no redirect_valid_o after reset release unless a new event arrives.

Verification
REQ-030 stallreq_ex_i=1 only, RUN -> stall_o=5'b00111, flush_o=5'b01000, redirect_valid_o=0.
REQ-031 branch_flag_i=1, target 32'h1c00_0100, fetch_ready_i=0 for 2 cycles then 1 -> flush_o=5'b00110 first cycle; WAIT outputs (stall 00001, flush 00010, pc 32'h1c00_0100) 2 cycles; RUN after acceptance.
REQ-032 excp_i=1, ertn_i=1, branch_flag_i=1 same cycle, eentry_i=32'h1c00_8000, excp_num_i=4'h5 -> flush_o=5'b11111, redirect_pc_o=32'h1c00_8000, excp_num_o=4'h5 next cycle.
REQ-033 In WAIT for branch target 32'h100, excp_i=1 eentry_i=32'h200 -> redirect_pc_o=32'h200 that cycle and onward until fetch_ready_i=1.
REQ-034 stallreq_if_i held 1 for WDOG_MAX cycles (WDOG_MAX=16'h0010 in bench) -> hang_o=1 after 16 stall cycles, remains 1 after stall drops, clears only on rst=0.
REQ-035 rst=0 during WAIT -> next cycle redirect_valid_o=0, stall_o=0, flush_o=0, hang_o=0.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// ============================================================================
// Module   : pipe_ctrl_if
// Purpose  : Stall/flush/redirect bundle between the pipeline and pipe_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_ctrl_if;
    logic        stallreq_if_i;
    logic        stallreq_id_i;
    logic        stallreq_ex_i;
    logic        stallreq_mem_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        excp_i;
    logic [3:0]  excp_num_i;
    logic [31:0] eentry_i;
    logic        ertn_i;
    logic [31:0] era_i;
    logic        fetch_ready_i;
    logic [4:0]  stall_o;
    logic [4:0]  flush_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic [3:0]  excp_num_o;
    logic        hang_o;

    // Controller side
    modport slave (
        input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        input  branch_flag_i, branch_target_i,
        input  excp_i, excp_num_i, eentry_i,
        input  ertn_i, era_i,
        input  fetch_ready_i,
        output stall_o, flush_o, redirect_valid_o, redirect_pc_o,
        output excp_num_o, hang_o
    );

    // Pipeline side
    modport master (
        output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        output branch_flag_i, branch_target_i,
        output excp_i, excp_num_i, eentry_i,
        output ertn_i, era_i,
        output fetch_ready_i,
        input  stall_o, flush_o, redirect_valid_o, redirect_pc_o,
        input  excp_num_o, hang_o
    );
endinterface

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : 5-stage pipeline stall/flush/redirect controller with watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl #(
    parameter logic [15:0] WDOG_MAX = 16'hFFFF
) (
    input  wire logic       clk,
    input  wire logic       rst,
    pipe_ctrl_if.slave      bus
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam logic [4:0] C_FLUSH_ALL    = 5'b11111;
    localparam logic [4:0] C_FLUSH_BRANCH = 5'b00110;
    localparam logic [4:0] C_STALL_WAIT   = 5'b00001;
    localparam logic [4:0] C_FLUSH_WAIT   = 5'b00010;

    state_e      state_q,    state_d;
    logic [31:0] tgt_q,      tgt_d;
    logic [3:0]  excp_num_q, excp_num_d;
    logic [15:0] wdog_q,     wdog_d;
    logic        hang_q,     hang_d;

    logic [2:0]  w_stall_lvl;
    logic [4:0]  w_lvl_stall;
    logic [4:0]  w_lvl_flush;
    logic        w_trap;
    logic [31:0] w_trap_pc;
    logic [4:0]  w_stall;
    logic [4:0]  w_flush;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;

    // Deepest requesting stage wins: everything upstream of it holds.
    always_comb begin
        w_stall_lvl = 3'd0;
        if (bus.stallreq_mem_i)     w_stall_lvl = 3'd4;
        else if (bus.stallreq_ex_i) w_stall_lvl = 3'd3;
        else if (bus.stallreq_id_i) w_stall_lvl = 3'd2;
        else if (bus.stallreq_if_i) w_stall_lvl = 3'd1;
    end

    always_comb begin
        w_lvl_stall = 5'b00000;
        w_lvl_flush = 5'b00000;
        case (w_stall_lvl)
            3'd1: begin w_lvl_stall = 5'b00001; w_lvl_flush = 5'b00010; end
            3'd2: begin w_lvl_stall = 5'b00011; w_lvl_flush = 5'b00100; end
            3'd3: begin w_lvl_stall = 5'b00111; w_lvl_flush = 5'b01000; end
            3'd4: begin w_lvl_stall = 5'b01111; w_lvl_flush = 5'b10000; end
            default: begin w_lvl_stall = 5'b00000; w_lvl_flush = 5'b00000; end
        endcase
    end

    assign w_trap    = bus.excp_i | bus.ertn_i;
    assign w_trap_pc = bus.excp_i ? bus.eentry_i : bus.era_i;

    always_comb begin
        state_d       = state_q;
        tgt_d         = tgt_q;
        excp_num_d    = excp_num_q;
        w_stall       = 5'b00000;
        w_flush       = 5'b00000;
        w_redirect    = 1'b0;
        w_redirect_pc = 32'h0;

        if (rst) begin
            case (state_q)
                ST_RUN: begin
                    if (w_trap) begin
                        w_flush       = C_FLUSH_ALL;
                        w_redirect    = 1'b1;
                        w_redirect_pc = w_trap_pc;
                    end else if (bus.branch_flag_i) begin
                        w_flush       = C_FLUSH_BRANCH;
                        w_redirect    = 1'b1;
                        w_redirect_pc = bus.branch_target_i;
                    end else begin
                        w_stall = w_lvl_stall;
                        w_flush = w_lvl_flush;
                    end
                end
                ST_WAIT: begin
                    // Branches are dropped here; only commit-stage traps can replace the target.
                    if (w_trap) begin
                        w_flush       = C_FLUSH_ALL;
                        w_redirect    = 1'b1;
                        w_redirect_pc = w_trap_pc;
                    end else begin
                        w_stall       = C_STALL_WAIT;
                        w_flush       = C_FLUSH_WAIT;
                        w_redirect    = 1'b1;
                        w_redirect_pc = tgt_q;
                    end
                end
                default: begin
                    w_stall = 5'b00000;
                    w_flush = 5'b00000;
                end
            endcase

            if (bus.excp_i) begin
                excp_num_d = bus.excp_num_i;
            end

            if (w_redirect) begin
                if (bus.fetch_ready_i) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_WAIT;
                    tgt_d   = w_redirect_pc;
                end
            end
        end
    end

    // Watchdog counts consecutive cycles with the PC held.
    always_comb begin
        wdog_d = 16'h0;
        if (w_stall[0]) begin
            wdog_d = (wdog_q >= WDOG_MAX) ? WDOG_MAX : wdog_q + 16'd1;
        end
        hang_d = hang_q | (wdog_d == WDOG_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            tgt_q      <= 32'h0;
            excp_num_q <= 4'h0;
            wdog_q     <= 16'h0;
            hang_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            excp_num_q <= excp_num_d;
            wdog_q     <= wdog_d;
            hang_q     <= hang_d;
        end
    end

    assign bus.stall_o          = w_stall;
    assign bus.flush_o          = w_flush;
    assign bus.redirect_valid_o = w_redirect;
    assign bus.redirect_pc_o    = w_redirect_pc;
    assign bus.excp_num_o       = excp_num_q;
    assign bus.hang_o           = hang_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// Module   : tb_pipe_ctrl
// Purpose  : Scoreboard bench for pipe_ctrl against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

    localparam logic [15:0] WDOG_MAX = 16'h0010;

    typedef struct {
        bit          rst;
        bit          s_if, s_id, s_ex, s_mem;
        bit          br;
        logic [31:0] bt;
        bit          excp;
        logic [3:0]  en;
        logic [31:0] ee;
        bit          ertn;
        logic [31:0] era;
        bit          fr;
    } stim_t;

    typedef struct {
        string       tag;
        logic [4:0]  stall;
        logic [4:0]  flush;
        logic        rv;
        logic [31:0] pc;
        logic [3:0]  en;
        logic        hang;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if u_if ();

    pipe_ctrl #(.WDOG_MAX(WDOG_MAX)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference state: pending redirect, its target, last cause, stall run length, hang.
    bit          m_wait   = 1'b0;
    logic [31:0] m_tgt    = 32'h0;
    logic [3:0]  m_en     = 4'h0;
    int          m_run    = 0;
    bit          m_hang   = 1'b0;

    function automatic stim_t idle();
        stim_t s;
        s.rst = 1'b1; s.s_if = 0; s.s_id = 0; s.s_ex = 0; s.s_mem = 0;
        s.br = 0; s.bt = 32'h0; s.excp = 0; s.en = 4'h0; s.ee = 32'h0;
        s.ertn = 0; s.era = 32'h0; s.fr = 1'b1;
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input string tag, input stim_t s);
        exp_t e;
        int   lvl;
        @(posedge clk);
        #1;
        rst                     = s.rst;
        u_if.stallreq_if_i      = s.s_if;
        u_if.stallreq_id_i      = s.s_id;
        u_if.stallreq_ex_i      = s.s_ex;
        u_if.stallreq_mem_i     = s.s_mem;
        u_if.branch_flag_i      = s.br;
        u_if.branch_target_i    = s.bt;
        u_if.excp_i             = s.excp;
        u_if.excp_num_i         = s.en;
        u_if.eentry_i           = s.ee;
        u_if.ertn_i             = s.ertn;
        u_if.era_i              = s.era;
        u_if.fetch_ready_i      = s.fr;

        e.tag = tag; e.stall = 5'b0; e.flush = 5'b0; e.rv = 1'b0; e.pc = 32'h0;
        e.en = m_en; e.hang = m_hang;

        if (!s.rst) begin
            q_exp.push_back(e);
            m_wait = 0; m_tgt = 32'h0; m_en = 4'h0; m_run = 0; m_hang = 0;
            return;
        end

        if (s.excp || s.ertn) begin
            e.flush = 5'b11111; e.rv = 1'b1;
            e.pc = s.excp ? s.ee : s.era;
        end else if (m_wait) begin
            e.stall = 5'b00001; e.flush = 5'b00010; e.rv = 1'b1; e.pc = m_tgt;
        end else if (s.br) begin
            e.flush = 5'b00110; e.rv = 1'b1; e.pc = s.bt;
        end else begin
            lvl = s.s_mem ? 4 : s.s_ex ? 3 : s.s_id ? 2 : s.s_if ? 1 : 0;
            e.stall = 5'((1 << lvl) - 1);
            e.flush = (lvl == 0) ? 5'b0 : 5'(1 << lvl);
        end
        q_exp.push_back(e);

        if (s.excp) m_en = s.en;
        if (e.rv) begin
            if (s.fr) m_wait = 0;
            else begin m_wait = 1; m_tgt = e.pc; end
        end
        if (e.stall[0]) m_run = (m_run >= int'(WDOG_MAX)) ? int'(WDOG_MAX) : m_run + 1;
        else            m_run = 0;
        if (m_run == int'(WDOG_MAX)) m_hang = 1;
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                chk({e.tag, ".stall"}, 32'(u_if.stall_o),          32'(e.stall));
                chk({e.tag, ".flush"}, 32'(u_if.flush_o),          32'(e.flush));
                chk({e.tag, ".rv"},    32'(u_if.redirect_valid_o), 32'(e.rv));
                chk({e.tag, ".pc"},    u_if.redirect_pc_o,         e.pc);
                chk({e.tag, ".en"},    32'(u_if.excp_num_o),       32'(e.en));
                chk({e.tag, ".hang"},  32'(u_if.hang_o),           32'(e.hang));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        u_if.stallreq_if_i = 0; u_if.stallreq_id_i = 0; u_if.stallreq_ex_i = 0;
        u_if.stallreq_mem_i = 0; u_if.branch_flag_i = 0; u_if.branch_target_i = 0;
        u_if.excp_i = 0; u_if.excp_num_i = 0; u_if.eentry_i = 0; u_if.ertn_i = 0;
        u_if.era_i = 0; u_if.fetch_ready_i = 0;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        s = idle(); s.rst = 0; step("reset", s);
        s = idle();            step("idle", s);

        s = idle(); s.s_ex = 1;                     step("ex_stall", s);
        s = idle(); s.s_if = 1; s.s_mem = 1;        step("mem_stall", s);
        s = idle(); s.s_id = 1;                     step("id_stall", s);

        s = idle(); s.br = 1; s.bt = 32'h1c00_0100; s.fr = 0; s.s_mem = 1; step("br_issue", s);
        s = idle(); s.fr = 0; s.s_ex = 1;           step("br_wait1", s);
        s = idle(); s.fr = 1; s.br = 1; s.bt = 32'hdead_0000; step("br_wait2", s);
        s = idle();                                 step("br_done", s);

        s = idle(); s.excp = 1; s.ertn = 1; s.br = 1; s.ee = 32'h1c00_8000;
        s.era = 32'h1234_5678; s.en = 4'h5; s.bt = 32'h4; step("trap_prio", s);
        s = idle();                                 step("trap_after", s);
        s = idle(); s.ertn = 1; s.era = 32'h0000_0abc; s.en = 4'h9; step("ertn", s);

        s = idle(); s.br = 1; s.bt = 32'h100; s.fr = 0; step("wo_br", s);
        s = idle(); s.excp = 1; s.ee = 32'h200; s.en = 4'h3; s.fr = 0; step("wo_excp", s);
        s = idle(); s.fr = 0;                       step("wo_hold1", s);
        s = idle(); s.fr = 0; s.s_mem = 1;          step("wo_hold2", s);
        s = idle(); s.fr = 1;                       step("wo_accept", s);
        s = idle();                                 step("wo_run", s);

        for (int i = 0; i < 20; i++) begin
            s = idle(); s.s_if = 1; step("wdog", s);
        end
        s = idle(); for (int i = 0; i < 3; i++) step("wdog_sticky", s);
        s = idle(); s.br = 1; s.bt = 32'h888; s.fr = 0; step("rw_br", s);
        s = idle(); s.fr = 0; step("rw_wait", s);
        s = idle(); s.rst = 0; s.fr = 0; step("rw_reset", s);
        s = idle(); s.fr = 0; step("rw_after1", s);
        s = idle(); s.fr = 0; step("rw_after2", s);

        for (int i = 0; i < 3000; i++) begin
            s = idle();
            s.rst   = ($urandom_range(0, 99) != 0);
            s.s_if  = ($urandom_range(0, 2) == 0);
            s.s_id  = ($urandom_range(0, 3) == 0);
            s.s_ex  = ($urandom_range(0, 4) == 0);
            s.s_mem = ($urandom_range(0, 5) == 0);
            s.br    = ($urandom_range(0, 5) == 0);
            s.bt    = $urandom;
            s.excp  = ($urandom_range(0, 15) == 0);
            s.en    = 4'($urandom);
            s.ee    = $urandom;
            s.ertn  = ($urandom_range(0, 15) == 0);
            s.era   = $urandom;
            s.fr    = ($urandom_range(0, 2) != 0);
            step("rand", s);
        end

        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(q_exp.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
